// File: rtl/mul_pre_reduce.sv
// mul_pre_reduce: digit-serial MSB-first multiplier producing the exact A*B product for the reducer.
// P is registered and only changes on the completion edge, flagged by a one-cycle done strobe.
module mul_pre_reduce #(
  parameter int A_W   = 256,
  parameter int B_W   = 44,
  parameter int DIGIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [A_W-1:0]       A,
  input  logic [B_W-1:0]       B,
  output logic [A_W+B_W-1:0]   P,
  output logic                 busy,
  output logic                 done
);
  localparam int P_W   = A_W + B_W;
  localparam int STEPS = B_W / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t               state_q, state_d;
  logic [A_W-1:0]       a_q, a_d;
  logic [B_W-1:0]       b_q, b_d;
  logic [P_W-1:0]       acc_q, acc_d;
  logic [P_W-1:0]       p_q, p_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic [DIGIT-1:0]     digit;
  logic [A_W+DIGIT-1:0] pp;
  logic [P_W-1:0]       step;
  logic                 load, run, last;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  always_comb begin
    load    = (state_q == IDLE) && start;
    run     = (state_q == RUN);
    last    = run && (cnt_q == '0);
    state_d = load ? RUN : last ? IDLE : state_q;
  end
  // Horner step: shift the running sum one digit and add A times the top digit of B.
  always_comb begin
    digit  = b_q[B_W-1 -: DIGIT];
    pp     = {{DIGIT{1'b0}}, a_q} * {{A_W{1'b0}}, digit};
    step   = {acc_q[P_W-DIGIT-1:0], {DIGIT{1'b0}}} + {{(B_W-DIGIT){1'b0}}, pp};
    a_d    = load ? A : a_q;
    b_d    = load ? B : run ? (b_q << DIGIT) : b_q;
    acc_d  = load ? '0 : run ? step : acc_q;
    cnt_d  = load ? CNT_W'(STEPS - 1) : (run && !last) ? cnt_q - CNT_W'(1) : cnt_q;
    p_d    = last ? step : p_q;
    done_d = last;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      p_q    <= '0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      p_q    <= p_d;
      done_q <= done_d;
    end
  always_comb begin
    busy = (state_q == RUN);
    done = done_q;
    P    = p_q;
  end
endmodule

// File: tb/tb_mul_pre_reduce.sv
// tb_mul_pre_reduce: directed and randomized checks of mul_pre_reduce against plain A*B arithmetic.
module tb_mul_pre_reduce;
  localparam int A_W   = 256;
  localparam int B_W   = 44;
  localparam int P_W   = A_W + B_W;
  localparam int STEPS = 11;
  logic           clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [A_W-1:0] A = '0;
  logic [B_W-1:0] B = '0;
  logic [P_W-1:0] P;
  logic           busy, done;
  int             n_chk = 0, n_pass = 0;
  logic [P_W-1:0] p_ref = '0, pend = '0;
  mul_pre_reduce dut (.clk(clk), .reset(reset), .start(start), .A(A), .B(B), .P(P), .busy(busy), .done(done));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [P_W-1:0] obs, input logic [P_W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s got=%0b exp=%0b", tag, obs, exp);
  endtask
  function automatic logic [A_W-1:0] rnd_a();
    logic [A_W-1:0] v = '0;
    for (int i = 0; i < A_W / 32; i++) v = {v[A_W-33:0], $urandom()};
    return v;
  endfunction
  function automatic logic [B_W-1:0] rnd_b();
    return B_W'({$urandom(), $urandom()});
  endfunction
  function automatic logic [P_W-1:0] prod(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    return P_W'(a) * P_W'(b);
  endfunction
  task automatic launch(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    A = a; B = b; start = 1'b1;
    pend = prod(a, b);
    tick();
    start = 1'b0;
    chk1("launch_busy", busy, 1'b1);
    chk1("launch_done", done, 1'b0);
    chk("launch_P_held", P, p_ref);
  endtask
  // Runs the remaining digit cycles with garbage on A/B; poke raises start mid-run (must be ignored).
  task automatic body(input int poke);
    for (int i = 1; i < STEPS; i++) begin
      A = rnd_a(); B = rnd_b(); start = (i == poke);
      if (i == poke) begin A = 5; B = 7; end
      tick();
      chk1("run_busy", busy, 1'b1);
      chk1("run_done", done, 1'b0);
      chk("run_P_held", P, p_ref);
    end
    start = 1'b0;
    tick();
    chk1("end_done", done, 1'b1);
    chk1("end_busy", busy, 1'b0);
    chk("end_P", P, pend);
    p_ref = pend;
  endtask
  task automatic idle_after();
    tick();
    chk1("idle_done", done, 1'b0);
    chk1("idle_busy", busy, 1'b0);
    chk("idle_P", P, p_ref);
  endtask
  initial begin
    logic [P_W-1:0] c;
    repeat (2) tick();
    chk("rst_P", P, '0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    reset = 1'b1;
    repeat (2) idle_after();
    launch(1, 1); body(0); idle_after();
    chk("one_P", P, P_W'(1));
    launch('1, '1); body(0); idle_after();
    c = '0 - (P_W'(1) << 256) - (P_W'(1) << 44) + P_W'(1);
    chk("max_P", P, c);
    launch(A_W'(64'h0123456789ABCDEF), '0); body(0); idle_after();
    chk("zero_P", P, '0);
    launch(1, B_W'(1) << 43); body(0); idle_after();
    chk("b43_P", P, P_W'(1) << 43);
    launch(3, 3); body(3); idle_after(); idle_after();
    chk("poke_P", P, P_W'(9));
    launch(rnd_a(), rnd_b()); body(0);
    launch(2, 3); body(0); idle_after();
    chk("b2b_P", P, P_W'(6));
    launch(rnd_a(), rnd_b());
    repeat (4) tick();
    reset = 1'b0;
    #1;
    chk("arst_P", P, '0);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_done", done, 1'b0);
    p_ref = '0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (13) idle_after();
    launch(rnd_a(), rnd_b()); body(0); idle_after();
    for (int r = 0; r < 16; r++) begin
      launch(rnd_a(), rnd_b());
      body(int'($urandom_range(0, 14)));
      if ($urandom_range(0, 1) == 0) idle_after();
    end
    idle_after();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mul_pre_reduce.md
# mul_pre_reduce

Digit-serial multiplier that forms the exact 300-bit product of a 256-bit field operand and a 44-bit scalar. It is the stage directly upstream of the modular reduction block. Its registered output `P` drives the reducer's 300-bit `X` input and stays stable until the next product completes. It uses the same start/busy handshake style as the reducer and adds a one-cycle `done` strobe for chaining.

## Interface

Parameters:
- `A_W` — 256 — width of operand A (field element).
- `B_W` — 44 — width of operand B (scalar).
- `DIGIT` — 4 — bits of B consumed per cycle. Must divide `B_W`.
- `P_W` — `A_W+B_W` (300) — product width. Derived, not overridable.

Ports:
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `reset`  in  1  — asynchronous, active-low (asserted when 0).
- `start`  in  1  — request a multiply; sampled only in IDLE.
- `A`  in  `A_W`  — multiplicand; captured on the accepted `start` edge.
- `B`  in  `B_W`  — multiplier; captured on the accepted `start` edge.
- `P`  out  `P_W`  — registered product. Feeds the reducer `X`.
- `busy`  out  1  — high while a multiply is in progress.
- `done`  out  1  — one-cycle pulse when `P` updates.

## Operation

- States: IDLE, RUN. `done` is a registered flag, not a separate state.
- IDLE, `start`=1 at an edge:
  - latch A into `a_q`, B into `b_q`;
  - clear accumulator `acc` (`P_W` bits);
  - load digit counter `cnt` = `B_W/DIGIT`-1 (10);
  - set `busy`=1 and go to RUN.
- RUN, each edge:
  - `acc` <= (`acc` << `DIGIT`) + `a_q` * `b_q[B_W-1 -: DIGIT]`. This is MSB-first Horner.
  - `b_q` shifts left by `DIGIT`.
- Last RUN cycle (`cnt`==0), at that edge:
  - `P` <= final sum;
  - `busy` <= 0, `done` <= 1;
  - return to IDLE.
- Otherwise `cnt` decrements.
- Arithmetic: the partial product `a_q`*digit is `A_W+DIGIT` bits. `acc` never overflows `P_W`, because the maximum result (2^256-1)(2^44-1) < 2^300. No truncation is permitted at any step.
- `start` while `busy`=1 is ignored. Captured operands are unaffected, and A/B may change freely.
- `P` is written only at completion. It holds its value through IDLE and through a subsequent RUN.
- `done` is forced to 0 on every edge except the completion edge.
- Reset (async assert, any state):
  - state goes to IDLE;
  - `P`=0, `busy`=0, `done`=0;
  - `acc`, `cnt`, `a_q`, `b_q` are cleared.
  - An in-flight multiply is discarded, and no `done` is produced for it.
- Reset deassertion is synchronised externally. The block is ready at the first rising edge with `reset`=1.

## Timing

- `start` sampled at edge k: `busy` is high from edge k.
- Edges k+1 … k+11 perform the 11 digit steps (`B_W/DIGIT`).
- At edge k+11: `P` is valid, `busy` falls, `done` rises.
- Latency from the start edge to `P` valid is `B_W/DIGIT` cycles (11 at defaults). It does not depend on the data.
- `done` is high for exactly the cycle after edge k+11 and cleared at edge k+12.
- Back-to-back operation: `start` is accepted at edge k+12 (same cycle `done` is high). Throughput is one product per 12 cycles.
- `start` held continuously high launches a new multiply at every IDLE edge.
- The downstream reducer may sample `P` on `done`. `P` is stable until the next completion edge (earliest k+23).

## Test plan

- A=1, B=1, pulse `start`:
  - `busy` is high for 11 cycles;
  - `done` pulses once;
  - `P`=1;
  - `busy`/`done`/`P` are 0 before the first start after reset.
- A=2^256-1, B=2^44-1: `P` = 2^300 - 2^256 - 2^44 + 1, exact, with no overflow.
- A=0x123456789ABCDEF, B=0: `P`=0.
- A=1, B=2^43, feeding the reducer: `P`=1<<43.
- Assert `start` with A=5,B=7 at cycle 3 of an A=3,B=3 run:
  - the first result `P`=9 arrives at the original time;
  - the second request is ignored;
  - `done` pulses only once.
- Two further scenarios:
  - Assert `reset` low mid-RUN: `P`, `busy`, `done` go to 0 immediately and no `done` follows. A new start after release gives the correct product.
  - Start accepted in the `done` cycle (A=2,B=3): the first `P` stays held until the second completes 11 cycles later with `P`=6.
